// File: rtl/bcd_digit_seq.sv
// bcd_digit_seq: drives an upstream binary-to-decimal converter one digit
// at a time and assembles its LSD-first digits into a packed BCD word.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start_pls, bin_in     one-cycle start, value sampled on that cycle
//   bin_req_pls, bin_out  conversion request and latched value upstream
//   next_quotient_pls     advance upstream to the next digit
//   dec_in[3:0]           current upstream digit ([7:4] unused)
//   busy, done_pls        sequence active / one-cycle completion
//   bcd_out, nz_digits    packed result and significant-digit count
//   dig_err               sticky flag for a captured digit above 9
module bcd_digit_seq #(
  parameter int NDIG   = 9,
  parameter int SETTLE = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_pls,
  input  logic [26:0]       bin_in,
  output logic              bin_req_pls,
  output logic [26:0]       bin_out,
  output logic              next_quotient_pls,
  input  logic [7:0]        dec_in,
  output logic              busy,
  output logic              done_pls,
  output logic [4*NDIG-1:0] bcd_out,
  output logic [3:0]        nz_digits,
  output logic              dig_err
);

  localparam int KW = $clog2(NDIG + 1);
  localparam int CW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((SETTLE > 1) ? SETTLE - 2 : 0);
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CAPT,
    NEXT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]     cnt;
  logic [KW-1:0]     k;
  logic [4*NDIG-1:0] dig_q;
  logic [4*NDIG-1:0] dig_cap;
  logic [3:0]        nz_cap;
  logic [3:0]        digit;
  logic              digit_bad;
  logic              last_cap;
  logic              start_ok;
  logic              unused_hi;

  assign unused_hi = ^dec_in[7:4];

  assign digit_bad = (dec_in[3:0] > 4'd9);
  assign digit     = digit_bad ? 4'd0 : dec_in[3:0];
  assign last_cap  = (k == K_LAST);
  assign start_ok  = (state == IDLE) && start_pls;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Moore outputs
  always_comb begin
    state_nxt         = state;
    bin_req_pls       = 1'b0;
    next_quotient_pls = 1'b0;
    done_pls          = 1'b0;
    busy              = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_pls) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        bin_req_pls = 1'b1;
        state_nxt   = (SETTLE > 1) ? WAIT : CAPT;
      end
      NEXT: begin
        next_quotient_pls = 1'b1;
        state_nxt         = (SETTLE > 1) ? WAIT : CAPT;
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          state_nxt = CAPT;
        end
      end
      CAPT: begin
        state_nxt = last_cap ? DONE : NEXT;
      end
      DONE: begin
        done_pls  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Settle counter: runs only while waiting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Digit vector with the current capture merged into slot k
  always_comb begin
    dig_cap = dig_q;
    for (int i = 0; i < NDIG; i++) begin
      if (k == KW'(i)) begin
        dig_cap[4*i +: 4] = digit;
      end
    end
  end

  // Highest nonzero slot plus one; a zero result still has one digit
  always_comb begin
    nz_cap = 4'd1;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_cap[4*i +: 4] != 4'd0) begin
        nz_cap = 4'(i + 1);
      end
    end
  end

  // Datapath. The result registers load on the final capture edge so
  // they are already valid while done_pls is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_out   <= '0;
      dig_q     <= '0;
      k         <= '0;
      dig_err   <= 1'b0;
      bcd_out   <= '0;
      nz_digits <= '0;
    end else begin
      if (start_ok) begin
        bin_out <= bin_in;
        dig_q   <= '0;
        k       <= '0;
        dig_err <= 1'b0;
      end
      if (state == CAPT) begin
        dig_q <= dig_cap;
        k     <= k + 1'b1;
        if (digit_bad) begin
          dig_err <= 1'b1;
        end
        if (last_cap) begin
          bcd_out   <= dig_cap;
          nz_digits <= nz_cap;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_digit_seq.sv
// tb_bcd_digit_seq: table vectors, reset abort and random runs of
// bcd_digit_seq against an arithmetic digit model and upstream model.
module tb_bcd_digit_seq;

  localparam int NDIG     = 9;
  localparam int SETTLE   = 6;
  localparam int PER      = SETTLE + 1;
  localparam int DONE_CYC = 1 + NDIG * PER;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start_pls;
  logic [26:0]       bin_in;
  logic              bin_req_pls;
  logic [26:0]       bin_out;
  logic              next_quotient_pls;
  logic [7:0]        dec_in;
  logic              busy;
  logic              done_pls;
  logic [4*NDIG-1:0] bcd_out;
  logic [3:0]        nz_digits;
  logic              dig_err;

  always #5 clk = ~clk;

  bcd_digit_seq #(.NDIG(NDIG), .SETTLE(SETTLE)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_pls         (start_pls),
    .bin_in            (bin_in),
    .bin_req_pls       (bin_req_pls),
    .bin_out           (bin_out),
    .next_quotient_pls (next_quotient_pls),
    .dec_in            (dec_in),
    .busy              (busy),
    .done_pls          (done_pls),
    .bcd_out           (bcd_out),
    .nz_digits         (nz_digits),
    .dig_err           (dig_err)
  );

  int ntests = 0;
  int nfail  = 0;

  function automatic logic [3:0] dig_of(input longint v, input int i);
    longint t = v;
    for (int j = 0; j < i; j++) t = t / 10;
    return 4'(t % 10);
  endfunction

  // Upstream converter: digit valid only from SETTLE cycles after a
  // pulse, 4'hF before that; optional bad digit injected at up_bad.
  int         up_idx = 0;
  int         up_age = 0;
  int         up_bad = -1;
  logic [3:0] up_junk = 4'h0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_idx <= 0;
      up_age <= 0;
    end else begin
      up_junk <= 4'($urandom);
      if (bin_req_pls) begin
        up_idx <= 0;
        up_age <= 1;
      end else if (next_quotient_pls) begin
        up_idx <= up_idx + 1;
        up_age <= 1;
      end else if (up_age < 100) begin
        up_age <= up_age + 1;
      end
    end
  end

  always_comb begin
    logic [3:0] d;
    d = dig_of(longint'(bin_out), up_idx);
    if (up_idx == up_bad) d = 4'hC;
    dec_in = (up_age >= SETTLE) ? {up_junk, d} : {up_junk, 4'hF};
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [35:0] mdl_bcd(input longint v, input int bad);
    logic [35:0] r = '0;
    for (int i = 0; i < NDIG; i++)
      r[4*i +: 4] = (i == bad) ? 4'd0 : dig_of(v, i);
    return r;
  endfunction

  function automatic logic [3:0] mdl_nz(input logic [35:0] b);
    int n = 1;
    for (int i = 0; i < NDIG; i++)
      if (b[4*i +: 4] != 4'd0) n = i + 1;
    return 4'(n);
  endfunction

  task automatic run_conv(input logic [26:0] v, input int bad,
                          input bit poke, input logic [35:0] eb,
                          input logic [3:0] en, input logic ee);
    int c;
    int nreq;
    int nnq;
    int dcyc;
    bit busy_ok;
    bit bo_ok;
    bit sp_ok;
    up_bad = bad;
    @(negedge clk);
    start_pls = 1'b1;
    bin_in    = v;
    @(negedge clk);
    start_pls = 1'b0;
    bin_in    = 27'($urandom);
    c = 1; nreq = 0; nnq = 0; dcyc = -1;
    busy_ok = 1'b1; bo_ok = 1'b1; sp_ok = 1'b1;
    while (c < 200 && dcyc < 0) begin
      if (bin_req_pls) begin
        nreq++;
        if (c != 1) sp_ok = 1'b0;
      end
      if (next_quotient_pls) begin
        nnq++;
        if (c != 1 + nnq * PER) sp_ok = 1'b0;
      end
      if (!busy) busy_ok = 1'b0;
      if (bin_out !== v) bo_ok = 1'b0;
      if (done_pls) dcyc = c;
      if (poke && c == 10) begin
        start_pls = 1'b1;
        bin_in    = 27'd5;
      end else begin
        start_pls = 1'b0;
      end
      if (dcyc < 0) begin
        @(negedge clk);
        c++;
      end
    end
    start_pls = 1'b0;
    chk("done_cycle", dcyc, DONE_CYC);
    chk("req_count", nreq, 1);
    chk("nq_count", nnq, NDIG - 1);
    chk("pulse_spacing", sp_ok, 1);
    chk("busy_run", busy_ok, 1);
    chk("bin_out_hold", bo_ok, 1);
    chk("bcd_out", bcd_out, eb);
    chk("nz_digits", nz_digits, en);
    chk("dig_err", dig_err, ee);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_single", done_pls, 0);
    repeat (3) @(negedge clk);
    chk("bcd_hold", bcd_out, eb);
    chk("bin_out_idle", bin_out, v);
  endtask

  typedef struct {
    logic [26:0] v;
    int          bad;
    bit          poke;
    logic [35:0] eb;
    logic [3:0]  en;
    logic        ee;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rst_vec;
    bit          rst_ok;
    bit          no_done;
    int          c;
    int          npl;

    tbl[0] = '{27'd91234567,  -1, 1'b0, 36'h091234567, 4'd8, 1'b0};
    tbl[1] = '{27'd0,         -1, 1'b0, 36'h000000000, 4'd1, 1'b0};
    tbl[2] = '{27'd134217727, -1, 1'b0, 36'h134217727, 4'd9, 1'b0};
    tbl[3] = '{27'd91234567,   2, 1'b0, 36'h091234067, 4'd8, 1'b1};
    tbl[4] = '{27'd42,        -1, 1'b1, 36'h000000042, 4'd2, 1'b0};
    tbl[5] = '{27'd1000000,   -1, 1'b0, 36'h001000000, 4'd7, 1'b0};

    start_pls = 1'b0;
    bin_in    = '0;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    rst_vec = {bin_req_pls, next_quotient_pls, busy, done_pls, dig_err,
               nz_digits, bin_out, bcd_out};
    chk("reset_state", rst_vec, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_conv(tbl[i].v, tbl[i].bad, tbl[i].poke,
               tbl[i].eb, tbl[i].en, tbl[i].ee);

    // Abort in WAIT after the third pulse
    up_bad = -1;
    @(negedge clk);
    start_pls = 1'b1;
    bin_in    = 27'd777777;
    @(negedge clk);
    start_pls = 1'b0;
    c = 1; npl = 0;
    while (c < 100 && npl < 3) begin
      if (bin_req_pls || next_quotient_pls) npl++;
      @(negedge clk);
      c++;
    end
    chk("abort_pulses", npl, 3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    rst_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rst_vec = {bin_req_pls, next_quotient_pls, busy, done_pls, dig_err,
                 nz_digits, bin_out, bcd_out};
      if (rst_vec != 0) rst_ok = 1'b0;
      @(negedge clk);
    end
    chk("reset_midrun", rst_ok, 1);
    reset_n = 1'b1;
    no_done = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done_pls || busy || bin_req_pls || next_quotient_pls)
        no_done = 1'b0;
    end
    chk("no_abort_activity", no_done, 1);
    run_conv(27'd123456789, -1, 1'b0, 36'h123456789, 4'd9, 1'b0);

    for (int r = 0; r < 8; r++) begin
      logic [26:0] v;
      int          bad;
      logic [35:0] eb;
      v   = 27'($urandom_range(0, 134217727));
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NDIG - 1))
                                        : -1;
      eb  = mdl_bcd(longint'(v), bad);
      run_conv(v, bad, 1'($urandom_range(0, 1)), eb, mdl_nz(eb),
               (bad >= 0));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/bcd_digit_seq.md
BCD_DIGIT_SEQ -- requirements
Module: bcd_digit_seq

Interface
REQ-001 Parameter NDIG, default 9: number of decimal digits collected per conversion (9 covers the 27-bit range).
REQ-002 Parameter SETTLE, default 6: clock cycles the upstream converter needs after each request or advance pulse before its digit output is valid.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start_pls  in  1  one-cycle start request.
REQ-006 bin_in  in  27  binary value to convert, sampled on the start cycle.
REQ-007 bin_req_pls  out  1  one-cycle conversion request to the upstream converter.
REQ-008 bin_out  out  27  latched copy of bin_in, driven to the upstream converter.
REQ-009 next_quotient_pls  out  1  one-cycle advance request to the upstream converter (next higher-order digit).
REQ-010 dec_in  in  8  upstream digit output; bits [3:0] carry the current digit and bits [7:4] are ignored.
REQ-011 busy  out  1  high while a sequence is in progress.
REQ-012 done_pls  out  1  one-cycle completion strobe.
REQ-013 bcd_out  out  4*NDIG  packed BCD result, digit 0 (least significant) in [3:0].
REQ-014 nz_digits  out  4  count of significant digits; 1 when the result is zero.
REQ-015 dig_err  out  1  set when any captured digit exceeds 9.

Function
REQ-016 The FSM shall have the states IDLE, REQ, WAIT, CAPT, NEXT and DONE.
REQ-017 IDLE, start_pls=1: latch bin_in into bin_out, clear the digit registers and dig_err, then go to REQ.
REQ-018 Every cycle other than an IDLE start cycle shall ignore start_pls, including while busy.
REQ-019 REQ shall assert bin_req_pls for exactly one cycle, then go to WAIT.
REQ-020 NEXT shall assert next_quotient_pls for exactly one cycle, then go to WAIT.
REQ-021 WAIT shall count SETTLE-1 cycles, then go to CAPT, so that capture occurs in the SETTLE-th cycle after a pulse cycle.
REQ-022 CAPT shall store dec_in[3:0] into digit slot k, where k is the capture index starting at 0, and then increment k.
REQ-023 After a capture, if k < NDIG, the FSM shall go to NEXT; otherwise it shall go to DONE.
REQ-024 The pulse period shall be SETTLE+1 cycles, which is 7 cycles at the defaults.
REQ-025 Exactly one bin_req_pls and NDIG-1 next_quotient_pls shall be issued per sequence.
REQ-026 DONE shall assert done_pls for one cycle, update bcd_out and nz_digits, then return to IDLE.
REQ-027 bcd_out and nz_digits shall hold their values until the next DONE.
REQ-028 busy shall be high from the REQ cycle through the DONE cycle inclusive, and low in IDLE.
REQ-029 Latency shall be as follows, with the start sampled at edge T: bin_req_pls occurs in cycle T+1, done_pls in cycle T+1+NDIG*(SETTLE+1), and busy is low in the cycle after that (T+65 at the defaults).
REQ-030 nz_digits shall equal the index of the highest nonzero digit plus 1, or 1 if all digits are zero.
REQ-031 A captured digit greater than 9 shall set dig_err, which is sticky until the next start.
REQ-032 A digit greater than 9 shall be stored as 0, and the sequence shall still complete normally.
REQ-033 bin_out shall remain stable from the start cycle until the next accepted start.

Reset
REQ-034 Asserting reset_n low at any time, including mid-sequence, shall immediately force the FSM to IDLE.
REQ-035 While reset is asserted, all outputs shall be 0: bin_req_pls, next_quotient_pls, busy, done_pls, bin_out, bcd_out, nz_digits and dig_err.
REQ-036 After reset is deasserted, the first start_pls sampled shall begin a fresh sequence, and no pulse shall be emitted for an aborted sequence.

Verification
REQ-037 Convert 91234567 (upstream model yields digits LSD-first) -> bcd_out=36'h091234567, nz_digits=8, dig_err=0, done_pls at cycle T+64.
REQ-038 Convert 0 -> bcd_out=0, nz_digits=1; convert 134217727 -> bcd_out=36'h134217727, nz_digits=9.
REQ-039 Count pulses and timing for one sequence -> exactly 1 bin_req_pls and 8 next_quotient_pls, spaced 7 cycles apart, with captures SETTLE cycles after each pulse.
REQ-040 Issue start_pls while busy with bin_in=5 -> the start is ignored, the original result is delivered, and bin_out is unchanged.
REQ-041 Assert reset_n=0 during WAIT after the 3rd pulse, then issue a new start -> all outputs are 0 during reset, no done_pls occurs for the aborted run, and the new run completes correctly.
REQ-042 Model returns 4'hC at digit 2 -> dig_err=1, slot 2 holds 0, and done_pls still asserts.
